// File: rtl/cpu_defs.sv
// Shared CPU definitions: exception flag bits, stall encoding and fetch FSM states.
// Pure declarations, no logic.
// Imported by every pipeline stage.
package cpu_defs;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL_IF = 32'h0000_0010;
    localparam logic [31:0] EXC_ADEL    = 32'h0000_0020;
    localparam logic [31:0] EXC_ADES    = 32'h0000_0040;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0100;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0200;
    localparam logic [31:0] EXC_RI      = 32'h0000_0400;
    localparam logic [31:0] EXC_OV      = 32'h0000_0800;
    localparam logic [31:0] EXC_ERET    = 32'h0000_4000;

    localparam logic [3:0]  STALL_NONE  = 4'b0000;

    typedef enum logic [2:0] {
        FETCH_IDLE   = 3'd0,
        FETCH_REQ    = 3'd1,
        FETCH_WAIT   = 3'd2,
        FETCH_HOLD   = 3'd3,
        FETCH_CANCEL = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/postif_fetch.sv
// Post-IF fetch: issues one PC on the instruction bus and hands the word (or AdEL) to postif_id.
// Latency: data is presented to ID in the same cycle as inst_data_ok_i; misaligned PCs one cycle after acceptance.
// Backpressure: stall_i holds the result in HOLD; if_ready_o stays low until the result transfers.
module postif_fetch
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    input  logic [3:0]  stall_i,
    input  logic        exception_i,
    output logic        postif_valid_o,
    output logic [31:0] postif_pc_o,
    output logic [31:0] postif_inst_o,
    output logic [31:0] postif_exception_type_o,
    output logic        stallreq_o
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc_r, pc_nxt;
    logic [31:0]  inst_r, inst_nxt;
    logic [31:0]  exc_r, exc_nxt;

    logic         data_vld;
    logic         transfer;
    logic         accept;
    logic         take_pc;

    // Raw validity before the flush mask; WAIT bypasses bus data straight to ID.
    assign data_vld       = (state == FETCH_HOLD) || ((state == FETCH_WAIT) && inst_data_ok_i);
    assign postif_valid_o = data_vld && !exception_i;
    assign transfer       = postif_valid_o && (stall_i == STALL_NONE);
    assign if_ready_o     = !exception_i && ((state == FETCH_IDLE) || transfer);
    assign accept         = if_valid_i && if_ready_o;
    assign stallreq_o     = !postif_valid_o && !exception_i;

    assign inst_req_o     = (state == FETCH_REQ);
    assign inst_addr_o    = pc_r;

    always_comb begin
        postif_pc_o             = RESET_PC;
        postif_inst_o           = NOP_INST;
        postif_exception_type_o = 32'h0000_0000;
        if (postif_valid_o) begin
            postif_pc_o             = pc_r;
            postif_inst_o           = (state == FETCH_WAIT) ? inst_rdata_i : inst_r;
            postif_exception_type_o = exc_r;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_r;
        inst_nxt  = inst_r;
        exc_nxt   = exc_r;
        take_pc   = 1'b0;
        case (state)
            FETCH_IDLE: begin
                take_pc = accept;
            end
            FETCH_REQ: begin
                if (exception_i) begin
                    state_nxt = inst_addr_ok_i ? FETCH_CANCEL : FETCH_IDLE;
                end else if (inst_addr_ok_i) begin
                    state_nxt = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (exception_i) begin
                    state_nxt = inst_data_ok_i ? FETCH_IDLE : FETCH_CANCEL;
                end else if (inst_data_ok_i) begin
                    if (transfer) begin
                        state_nxt = FETCH_IDLE;
                        take_pc   = accept;
                    end else begin
                        inst_nxt  = inst_rdata_i;
                        state_nxt = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (exception_i) begin
                    state_nxt = FETCH_IDLE;
                end else if (transfer) begin
                    state_nxt = FETCH_IDLE;
                    take_pc   = accept;
                end
            end
            FETCH_CANCEL: begin
                // The orphaned response must be absorbed before a new request can go out.
                if (inst_data_ok_i) begin
                    state_nxt = FETCH_IDLE;
                end
            end
            default: begin
                state_nxt = FETCH_IDLE;
            end
        endcase

        if (take_pc) begin
            pc_nxt = if_pc_i;
            if (if_pc_i[1:0] != 2'b00) begin
                exc_nxt   = EXC_ADEL_IF;
                inst_nxt  = NOP_INST;
                state_nxt = FETCH_HOLD;
            end else begin
                exc_nxt   = 32'h0000_0000;
                state_nxt = FETCH_REQ;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state  <= FETCH_IDLE;
            pc_r   <= 32'h0000_0000;
            inst_r <= 32'h0000_0000;
            exc_r  <= 32'h0000_0000;
        end else begin
            state  <= state_nxt;
            pc_r   <= pc_nxt;
            inst_r <= inst_nxt;
            exc_r  <= exc_nxt;
        end
    end

endmodule

// File: tb/tb_postif_fetch.sv
// Directed bench for postif_fetch: scoreboard of expected ID transfers plus per-cycle port checks.
module tb_postif_fetch;

    localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFFC;
    localparam logic [31:0] TB_NOP      = 32'h0000_0000;

    logic        clock_i;
    logic        reset_i;
    logic [31:0] if_pc_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic [3:0]  stall_i;
    logic        exception_i;
    logic        postif_valid_o;
    logic [31:0] postif_pc_o;
    logic [31:0] postif_inst_o;
    logic [31:0] postif_exception_type_o;
    logic        stallreq_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    postif_fetch #(
        .RESET_PC (TB_RESET_PC),
        .NOP_INST (TB_NOP)
    ) dut (
        .clock_i                 (clock_i),
        .reset_i                 (reset_i),
        .if_pc_i                 (if_pc_i),
        .if_valid_i              (if_valid_i),
        .if_ready_o              (if_ready_o),
        .inst_req_o              (inst_req_o),
        .inst_addr_o             (inst_addr_o),
        .inst_addr_ok_i          (inst_addr_ok_i),
        .inst_data_ok_i          (inst_data_ok_i),
        .inst_rdata_i            (inst_rdata_i),
        .stall_i                 (stall_i),
        .exception_i             (exception_i),
        .postif_valid_o          (postif_valid_o),
        .postif_pc_o             (postif_pc_o),
        .postif_inst_o           (postif_inst_o),
        .postif_exception_type_o (postif_exception_type_o),
        .stallreq_o              (stallreq_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Pops one expected entry for every cycle in which ID actually captures.
    task automatic sb_check();
        exp_t e;
        if (postif_valid_o === 1'b1 && stall_i == 4'b0000) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pc", postif_pc_o, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", postif_pc_o, e.pc);
                chk("sb_inst", postif_inst_o, e.inst);
                chk("sb_exc", postif_exception_type_o, e.exc);
            end
        end
    endtask

    task automatic sample();
        #3;
        sb_check();
    endtask

    task automatic next_cycle();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, postif_valid_o}, 32'd0);
        chk({tag, "_pc"}, postif_pc_o, TB_RESET_PC);
        chk({tag, "_inst"}, postif_inst_o, TB_NOP);
        chk({tag, "_exc"}, postif_exception_type_o, 32'd0);
    endtask

    // Accepts an aligned PC, then holds REQ one cycle without and one with addr_ok.
    task automatic fetch_req(input logic [31:0] pc);
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        sample();
        chk("acc_ready", {31'd0, if_ready_o}, 32'd1);
        chk("acc_req", {31'd0, inst_req_o}, 32'd0);
        next_cycle();
        if_valid_i = 1'b0;
        sample();
        chk("req_req", {31'd0, inst_req_o}, 32'd1);
        chk("req_addr", inst_addr_o, pc);
        chk("req_ready", {31'd0, if_ready_o}, 32'd0);
        chk("req_stallreq", {31'd0, stallreq_o}, 32'd1);
        next_cycle();
        inst_addr_ok_i = 1'b1;
        sample();
        chk("req_ack_req", {31'd0, inst_req_o}, 32'd1);
        chk("req_ack_addr", inst_addr_o, pc);
        next_cycle();
        inst_addr_ok_i = 1'b0;
    endtask

    initial begin
        reset_i        = 1'b1;
        if_pc_i        = 32'd0;
        if_valid_i     = 1'b0;
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'd0;
        stall_i        = 4'b0000;
        exception_i    = 1'b0;
        next_cycle();
        sample();
        chk_bubble("rst");
        chk("rst_req", {31'd0, inst_req_o}, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_o}, 32'd1);
        next_cycle();
        reset_i = 1'b0;

        // Aligned fetch, no stall: bypass in the data_ok cycle.
        sb.push_back('{pc: 32'hBFC0_0000, inst: 32'h2408_0001, exc: 32'd0});
        fetch_req(32'hBFC0_0000);
        sample();
        chk("wait_req", {31'd0, inst_req_o}, 32'd0);
        chk("wait_valid", {31'd0, postif_valid_o}, 32'd0);
        chk("wait_stallreq", {31'd0, stallreq_o}, 32'd1);
        next_cycle();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h2408_0001;
        sample();
        chk("byp_valid", {31'd0, postif_valid_o}, 32'd1);
        chk("byp_stallreq", {31'd0, stallreq_o}, 32'd0);
        chk("byp_ready", {31'd0, if_ready_o}, 32'd1);
        next_cycle();
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'h0;
        sample();
        chk("post_byp_valid", {31'd0, postif_valid_o}, 32'd0);
        chk("post_byp_ready", {31'd0, if_ready_o}, 32'd1);
        next_cycle();

        // Stall at data_ok, hold through three stalled cycles, then release.
        sb.push_back('{pc: 32'hBFC0_0000, inst: 32'h2408_0001, exc: 32'd0});
        fetch_req(32'hBFC0_0000);
        next_cycle();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h2408_0001;
        stall_i        = 4'b0011;
        sample();
        chk("stl_valid", {31'd0, postif_valid_o}, 32'd1);
        chk("stl_inst", postif_inst_o, 32'h2408_0001);
        chk("stl_ready", {31'd0, if_ready_o}, 32'd0);
        next_cycle();
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("hold_valid", {31'd0, postif_valid_o}, 32'd1);
            chk("hold_pc", postif_pc_o, 32'hBFC0_0000);
            chk("hold_inst", postif_inst_o, 32'h2408_0001);
            chk("hold_ready", {31'd0, if_ready_o}, 32'd0);
            chk("hold_stallreq", {31'd0, stallreq_o}, 32'd0);
            next_cycle();
        end
        stall_i = 4'b0000;
        sample();
        chk("rel_valid", {31'd0, postif_valid_o}, 32'd1);
        chk("rel_ready", {31'd0, if_ready_o}, 32'd1);
        next_cycle();
        sample();
        chk_bubble("rel_idle");
        next_cycle();

        // Misaligned PC goes straight to HOLD; next PC accepted on the transfer cycle.
        sb.push_back('{pc: 32'hBFC0_0002, inst: TB_NOP, exc: 32'h0000_0010});
        if_valid_i = 1'b1;
        if_pc_i    = 32'hBFC0_0002;
        sample();
        chk("mis_acc_ready", {31'd0, if_ready_o}, 32'd1);
        chk("mis_acc_req", {31'd0, inst_req_o}, 32'd0);
        next_cycle();
        if_pc_i = 32'hBFC0_0500;
        sb.push_back('{pc: 32'hBFC0_0500, inst: 32'h8C09_0004, exc: 32'd0});
        sample();
        chk("mis_valid", {31'd0, postif_valid_o}, 32'd1);
        chk("mis_exc", postif_exception_type_o, 32'h0000_0010);
        chk("mis_req", {31'd0, inst_req_o}, 32'd0);
        chk("b2b_ready", {31'd0, if_ready_o}, 32'd1);
        next_cycle();
        if_valid_i     = 1'b0;
        inst_addr_ok_i = 1'b1;
        sample();
        chk("b2b_req", {31'd0, inst_req_o}, 32'd1);
        chk("b2b_addr", inst_addr_o, 32'hBFC0_0500);
        next_cycle();
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h8C09_0004;
        sample();
        chk("b2b_valid", {31'd0, postif_valid_o}, 32'd1);
        next_cycle();
        inst_data_ok_i = 1'b0;

        // Flush while waiting: late DEADBEEF must never reach ID.
        fetch_req(32'hBFC0_0100);
        exception_i = 1'b1;
        sample();
        chk("fw_valid", {31'd0, postif_valid_o}, 32'd0);
        chk("fw_ready", {31'd0, if_ready_o}, 32'd0);
        chk("fw_stallreq", {31'd0, stallreq_o}, 32'd0);
        next_cycle();
        exception_i = 1'b0;
        sample();
        chk_bubble("cancel");
        chk("cancel_ready", {31'd0, if_ready_o}, 32'd0);
        chk("cancel_req", {31'd0, inst_req_o}, 32'd0);
        next_cycle();
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'hDEAD_BEEF;
        sample();
        chk_bubble("cancel_drop");
        chk("cancel_drop_ready", {31'd0, if_ready_o}, 32'd0);
        next_cycle();
        inst_data_ok_i = 1'b0;
        sample();
        chk("cancel_idle_ready", {31'd0, if_ready_o}, 32'd1);
        chk_bubble("cancel_idle");
        next_cycle();

        // Flush in REQ before addr_ok: request withdrawn, next PC accepted.
        if_valid_i = 1'b1;
        if_pc_i    = 32'hBFC0_0200;
        sample();
        next_cycle();
        if_valid_i  = 1'b0;
        exception_i = 1'b1;
        sample();
        chk("fr_req", {31'd0, inst_req_o}, 32'd1);
        chk("fr_ready", {31'd0, if_ready_o}, 32'd0);
        next_cycle();
        exception_i = 1'b0;
        if_valid_i  = 1'b1;
        if_pc_i     = 32'hBFC0_0380;
        sb.push_back('{pc: 32'hBFC0_0380, inst: 32'h3C08_0000, exc: 32'd0});
        sample();
        chk("fr_drop_req", {31'd0, inst_req_o}, 32'd0);
        chk("fr_new_ready", {31'd0, if_ready_o}, 32'd1);
        next_cycle();
        if_valid_i     = 1'b0;
        inst_addr_ok_i = 1'b1;
        sample();
        chk("fr_new_addr", inst_addr_o, 32'hBFC0_0380);
        chk("fr_new_req", {31'd0, inst_req_o}, 32'd1);
        next_cycle();
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = 32'h3C08_0000;
        sample();
        chk("fr_new_valid", {31'd0, postif_valid_o}, 32'd1);
        next_cycle();
        inst_data_ok_i = 1'b0;

        // Reset in the middle of WAIT.
        fetch_req(32'hBFC0_0400);
        reset_i = 1'b1;
        sample();
        next_cycle();
        reset_i = 1'b0;
        sample();
        chk_bubble("rst_wait");
        chk("rst_wait_req", {31'd0, inst_req_o}, 32'd0);
        chk("rst_wait_ready", {31'd0, if_ready_o}, 32'd1);
        chk("rst_wait_stallreq", {31'd0, stallreq_o}, 32'd1);
        next_cycle();

        chk("sb_leftover", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
